// File: rtl/path_delay_sequencer.sv
// rtl/path_delay_sequencer.sv - launches edges on a buffer chain and times their return in clock cycles
// Optional accumulator output sum_delay enabled by PATH_DELAY_SEQ_ACCUM_EN.
module path_delay_sequencer #(
  parameter int CNT_W      = 8,
  parameter int TRIALS_W   = 4,
  parameter int TIMEOUT    = 200,
  parameter int SETTLE_CYC = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [TRIALS_W-1:0]       num_trials,
  input  logic                      path_out,
  output logic                      path_in,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout_err,
  output logic [TRIALS_W-1:0]       trial_cnt,
  output logic [CNT_W-1:0]          last_delay,
  output logic [CNT_W-1:0]          min_delay,
  output logic [CNT_W-1:0]          max_delay
`ifdef PATH_DELAY_SEQ_ACCUM_EN
  ,
  output logic [CNT_W+TRIALS_W-1:0] sum_delay
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_sync1;
  logic                  r_po_s;
  logic                  r_path_in;
  logic                  r_busy;
  logic                  r_timeout_err;
  logic [TRIALS_W-1:0]   r_num;
  logic [TRIALS_W-1:0]   r_trial_cnt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_last_delay;
  logic [CNT_W-1:0]      r_min_delay;
  logic [CNT_W-1:0]      r_max_delay;
  logic                  w_match;
  logic                  w_timeout;
  logic                  w_last_trial;
  logic                  w_settle_end;
  logic [TRIALS_W-1:0]   w_trial_inc;

  // r_cnt equals the number of edges since the launch edge, so a loopback
  // matches when r_cnt==2: the depth of the synchroniser.
  assign w_match      = (r_po_s == r_path_in);
  assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_trial_inc  = r_trial_cnt + TRIALS_W'(1);
  assign w_last_trial = (w_trial_inc == r_num);
  assign w_settle_end = (r_cnt == CNT_W'(SETTLE_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = (num_trials == '0) ? S_DONE : S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT: begin
        if (w_match)        w_next = w_last_trial ? S_DONE : S_SETTLE;
        else if (w_timeout) w_next = S_DONE;
      end
      S_SETTLE: if (w_settle_end) w_next = S_LAUNCH;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

`ifdef PATH_DELAY_SEQ_ACCUM_EN
  logic [CNT_W+TRIALS_W-1:0] r_sum;
  always_ff @(posedge clk) begin
    if (!rst_n) r_sum <= '0;
    else if (r_state == S_IDLE && start) r_sum <= '0;
    else if (r_state == S_WAIT && w_match) r_sum <= r_sum + {{TRIALS_W{1'b0}}, r_cnt};
  end
  assign sum_delay = r_sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1       <= 1'b0;
      r_po_s        <= 1'b0;
      r_path_in     <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_num         <= '0;
      r_trial_cnt   <= '0;
      r_cnt         <= '0;
      r_last_delay  <= '0;
      r_min_delay   <= '1;
      r_max_delay   <= '0;
    end else begin
      r_sync1 <= path_out;
      r_po_s  <= r_sync1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num         <= num_trials;
            r_busy        <= 1'b1;
            r_timeout_err <= 1'b0;
            r_trial_cnt   <= '0;
            r_last_delay  <= '0;
            r_min_delay   <= '1;
            r_max_delay   <= '0;
          end
        end
        S_LAUNCH: begin
          r_path_in <= ~r_path_in;
          r_cnt     <= '0;
        end
        S_WAIT: begin
          if (w_match) begin
            r_last_delay <= r_cnt;
            r_min_delay  <= (r_cnt < r_min_delay) ? r_cnt : r_min_delay;
            r_max_delay  <= (r_cnt > r_max_delay) ? r_cnt : r_max_delay;
            r_trial_cnt  <= w_trial_inc;
            r_cnt        <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_timeout) r_timeout_err <= 1'b1;
          end
        end
        S_SETTLE: r_cnt <= r_cnt + CNT_W'(1);
        S_DONE:   r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  assign path_in     = r_path_in;
  assign busy        = r_busy;
  assign done        = (r_state == S_DONE);
  assign timeout_err = r_timeout_err;
  assign trial_cnt   = r_trial_cnt;
  assign last_delay  = r_last_delay;
  assign min_delay   = r_min_delay;
  assign max_delay   = r_max_delay;

endmodule
